// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment-bus type, the hex glyph patterns and the
// pattern-to-nibble decoder used by both the display encoder and the readback monitor.
package seg7_pkg;

  // Index 0 is segment a, index 6 is segment g.
  typedef logic [0:6] seg7_t;

  localparam seg7_t SEG7_0 = 7'b1111110;
  localparam seg7_t SEG7_1 = 7'b0110000;
  localparam seg7_t SEG7_2 = 7'b1101101;
  localparam seg7_t SEG7_3 = 7'b1111001;
  localparam seg7_t SEG7_4 = 7'b0110011;
  localparam seg7_t SEG7_5 = 7'b1011011;
  localparam seg7_t SEG7_6 = 7'b1011111;
  localparam seg7_t SEG7_7 = 7'b1110000;
  localparam seg7_t SEG7_8 = 7'b1111111;
  localparam seg7_t SEG7_9 = 7'b1111011;
  localparam seg7_t SEG7_A = 7'b1110111;
  localparam seg7_t SEG7_B = 7'b0011111;
  localparam seg7_t SEG7_C = 7'b1001110;
  localparam seg7_t SEG7_D = 7'b0111101;
  localparam seg7_t SEG7_E = 7'b1001111;
  localparam seg7_t SEG7_F = 7'b1000111;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } seg7_dec_t;

  typedef enum logic [1:0] {
    StBlank,
    StSettle,
    StHeld
  } filt_state_e;

  function automatic seg7_dec_t seg7_decode(seg7_t seg);
    seg7_dec_t res;
    res.legal  = 1'b1;
    res.nibble = 4'h0;
    case (seg)
      SEG7_0:  res.nibble = 4'h0;
      SEG7_1:  res.nibble = 4'h1;
      SEG7_2:  res.nibble = 4'h2;
      SEG7_3:  res.nibble = 4'h3;
      SEG7_4:  res.nibble = 4'h4;
      SEG7_5:  res.nibble = 4'h5;
      SEG7_6:  res.nibble = 4'h6;
      SEG7_7:  res.nibble = 4'h7;
      SEG7_8:  res.nibble = 4'h8;
      SEG7_9:  res.nibble = 4'h9;
      SEG7_A:  res.nibble = 4'hA;
      SEG7_B:  res.nibble = 4'hB;
      SEG7_C:  res.nibble = 4'hC;
      SEG7_D:  res.nibble = 4'hD;
      SEG7_E:  res.nibble = 4'hE;
      SEG7_F:  res.nibble = 4'hF;
      default: res.legal  = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Bundle between a multiplexed 7-segment display driver (master) and the
// scan decoder monitor (slave) that reads the display back.
interface seg7_scan_decoder_if
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) ();

  seg7_t                  segmentcode;
  logic [DIGITS-1:0]      anode;
  logic                   err_clr;
  logic [4*DIGITS-1:0]    digits;
  logic [DIGITS-1:0]      digit_valid;
  logic                   decode_err;
  logic [DIGITS-1:0]      err_digit;
  logic                   frame_done;

  modport master (
    output segmentcode, anode, err_clr,
    input  digits, digit_valid, decode_err, err_digit, frame_done
  );

  modport slave (
    input  segmentcode, anode, err_clr,
    output digits, digit_valid, decode_err, err_digit, frame_done
  );

endinterface

// File: rtl/seg7_stability_filter.sv
// Registers the segment/anode bus and strobes a capture once a one-hot anode and
// its segment pattern have been seen unchanged for STABLE_CYCLES samples.
module seg7_stability_filter
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  seg7_t             seg_i,
  input  logic [DIGITS-1:0] anode_i,
  output logic              cap_o,
  output seg7_t             cap_seg_o,
  output logic [DIGITS-1:0] cap_anode_o
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  seg7_t             seg_d, seg_q, seg_prev_q;
  logic [DIGITS-1:0] anode_d, anode_q, anode_prev_q;
  filt_state_e       state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic              one_hot, same, capture;

  assign one_hot = $onehot(anode_q);
  assign same    = (seg_q == seg_prev_q) && (anode_q == anode_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= '0;
      seg_prev_q   <= '0;
      anode_q      <= '0;
      anode_prev_q <= '0;
      state_q      <= StBlank;
      cnt_q        <= '0;
    end else begin
      seg_q        <= seg_d;
      seg_prev_q   <= seg_q;
      anode_q      <= anode_d;
      anode_prev_q <= anode_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    seg_d   = SEG_ACTIVE_LOW ? ~seg_i : seg_i;
    anode_d = SEG_ACTIVE_LOW ? ~anode_i : anode_i;
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (one_hot) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      StSettle, StHeld: begin
        if (!one_hot) begin
          state_d = StBlank;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = StSettle;
          cnt_d   = CntOne;
        end else if (state_q == StSettle) begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
    // Entry into SETTLE may already satisfy the count when STABLE_CYCLES is 1.
    if (state_d == StSettle && cnt_d == CntMax) begin
      capture = 1'b1;
      state_d = StHeld;
    end
  end

  always_comb begin
    cap_o       = capture;
    cap_seg_o   = seg_q;
    cap_anode_o = anode_q;
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment display: recovers each digit's hex value,
// flags illegal glyphs and pulses frame_done once every digit has been captured.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);

  logic                cap;
  seg7_t               cap_seg;
  logic [DIGITS-1:0]   cap_anode;
  seg7_dec_t           dec;

  logic [4*DIGITS-1:0] digits_d, digits_q;
  logic [DIGITS-1:0]   valid_d, valid_q;
  logic [DIGITS-1:0]   err_digit_d, err_digit_q;
  logic [DIGITS-1:0]   mask_d, mask_q;
  logic                decode_err_d, decode_err_q;
  logic                frame_done_d, frame_done_q;

  seg7_stability_filter #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES),
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_i      (bus.segmentcode),
    .anode_i    (bus.anode),
    .cap_o      (cap),
    .cap_seg_o  (cap_seg),
    .cap_anode_o(cap_anode)
  );

  assign dec = seg7_decode(cap_seg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q     <= '0;
      valid_q      <= '0;
      err_digit_q  <= '0;
      mask_q       <= '0;
      decode_err_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_digit_q  <= err_digit_d;
      mask_q       <= mask_d;
      decode_err_q <= decode_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_digit_d  = bus.err_clr ? '0 : err_digit_q;
    decode_err_d = bus.err_clr ? 1'b0 : decode_err_q;
    frame_done_d = &mask_q;
    mask_d       = frame_done_d ? '0 : mask_q;
    // Applied after err_clr so a same-cycle capture error keeps its flag.
    if (cap) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (cap_anode[d]) begin
          if (dec.legal) begin
            digits_d[4*d +: 4] = dec.nibble;
            valid_d[d]         = 1'b1;
            mask_d[d]          = 1'b1;
          end else begin
            err_digit_d[d]     = 1'b1;
            decode_err_d       = 1'b1;
            valid_d[d]         = 1'b0;
          end
        end
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.err_digit   = err_digit_q;
  assign bus.decode_err  = decode_err_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: an active-high and an active-low instance see the same
// logical stimulus and are both compared every cycle with a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int unsigned DIGITS = 4;
  localparam int          STABLE = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus_h ();
  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus_l ();

  seg7_scan_decoder #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE),
    .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_h (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_h)
  );

  seg7_scan_decoder #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE),
    .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_l (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_l)
  );

  int total = 0;
  int bad   = 0;
  int fd_count = 0;

  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Logical (active-high) stimulus currently applied
  logic [3:0] s_an  = '0;
  logic [6:0] s_seg = '0;
  logic       s_clr = 1'b0;

  // Reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_errd, m_mask;
  logic        m_derr, m_fd;
  int          run;
  logic [3:0]  prev_an, pend_an;
  logic [6:0]  prev_seg, pend_seg;
  logic        pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return {1'b1, 4'(i)};
    return 5'b0;
  endfunction

  // Model: a digit is captured one cycle after its anode/segment pair has been applied
  // for exactly STABLE consecutive cycles with a one-hot anode.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_digits = '0; m_valid = '0; m_errd = '0; m_mask = '0;
        m_derr = 1'b0; m_fd = 1'b0;
        run = 0; prev_an = '0; prev_seg = '0; pend = 1'b0;
        pend_an = '0; pend_seg = '0;
      end else begin
        m_fd = (m_mask == 4'hF);
        if (m_fd) m_mask = '0;
        if (s_clr) begin
          m_errd = '0;
          m_derr = 1'b0;
        end
        if (pend) begin
          logic [4:0] r;
          r = ref_dec(pend_seg);
          for (int d = 0; d < 4; d++) begin
            if (pend_an[d]) begin
              if (r[4]) begin
                m_digits[4*d +: 4] = r[3:0];
                m_valid[d] = 1'b1;
                m_mask[d]  = 1'b1;
              end else begin
                m_errd[d]  = 1'b1;
                m_derr     = 1'b1;
                m_valid[d] = 1'b0;
              end
            end
          end
        end
        if ($countones(s_an) != 1) run = 0;
        else if (run > 0 && s_an == prev_an && s_seg == prev_seg) run++;
        else run = 1;
        prev_an  = s_an;
        prev_seg = s_seg;
        pend     = (run == STABLE);
        pend_an  = s_an;
        pend_seg = s_seg;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("h_digits", 32'(bus_h.digits), 32'(m_digits));
        chk("h_valid", 32'(bus_h.digit_valid), 32'(m_valid));
        chk("h_err_digit", 32'(bus_h.err_digit), 32'(m_errd));
        chk("h_decode_err", 32'(bus_h.decode_err), 32'(m_derr));
        chk("h_frame_done", 32'(bus_h.frame_done), 32'(m_fd));
        chk("l_digits", 32'(bus_l.digits), 32'(m_digits));
        chk("l_valid", 32'(bus_l.digit_valid), 32'(m_valid));
        chk("l_err_digit", 32'(bus_l.err_digit), 32'(m_errd));
        chk("l_decode_err", 32'(bus_l.decode_err), 32'(m_derr));
        chk("l_frame_done", 32'(bus_l.frame_done), 32'(m_fd));
        if (bus_h.frame_done) fd_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input logic clr);
    s_an  = an;
    s_seg = sg;
    s_clr = clr;
    bus_h.anode       = an;
    bus_h.segmentcode = sg;
    bus_h.err_clr     = clr;
    bus_l.anode       = ~an;
    bus_l.segmentcode = ~sg;
    bus_l.err_clr     = clr;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] sg, input logic clr,
                      input int n);
    drive(an, sg, clr);
    tick();
    drive(an, sg, 1'b0);
    repeat (n - 1) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int fd_start;
    drive(4'b0000, 7'b0000000, 1'b0);
    repeat (3) tick();
    chk("rst_digits", 32'(bus_h.digits), 32'h0);
    chk("rst_valid", 32'(bus_h.digit_valid), 32'h0);
    chk("rst_err", 32'({bus_h.decode_err, bus_h.err_digit, bus_h.frame_done}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Digit 0 = '0': valid only after the 9th edge
    drive(4'b0001, 7'b1111110, 1'b0);
    repeat (8) tick();
    chk("t1_not_yet", 32'(bus_h.digit_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(bus_h.digit_valid), 32'h1);
    chk("t1_digit0", 32'(bus_h.digits[3:0]), 32'h0);
    tick();

    // Scan 1,2,3,4 across the four digits
    fd_start = fd_count;
    hold(4'b0001, 7'b0110000, 1'b0, 10);
    hold(4'b0010, 7'b1101101, 1'b0, 10);
    hold(4'b0100, 7'b1111001, 1'b0, 10);
    hold(4'b1000, 7'b0110011, 1'b0, 10);
    hold(4'b0000, 7'b0000000, 1'b0, 3);
    chk("scan_digits", 32'(bus_h.digits), 32'h4321);
    chk("scan_valid", 32'(bus_h.digit_valid), 32'hF);
    chk("scan_frames", 32'(fd_count - fd_start), 32'd1);

    // Segment toggling faster than the stability window never captures
    for (int i = 0; i < 8; i++) hold(4'b0010, (i % 2 == 0) ? 7'b1111110 : 7'b1111111, 1'b0, 5);
    chk("toggle_digits", 32'(bus_h.digits), 32'h4321);
    chk("toggle_valid", 32'(bus_h.digit_valid), 32'hF);

    // Illegal glyph on digit 2, then clear the sticky flags
    hold(4'b0100, 7'b1010101, 1'b0, 10);
    chk("ill_decode_err", 32'(bus_h.decode_err), 32'h1);
    chk("ill_err_digit", 32'(bus_h.err_digit), 32'h4);
    chk("ill_valid", 32'(bus_h.digit_valid), 32'hB);
    chk("ill_digits", 32'(bus_h.digits), 32'h4321);
    hold(4'b0000, 7'b0000000, 1'b1, 2);
    chk("clr_flags", 32'({bus_h.decode_err, bus_h.err_digit}), 32'h0);

    // Non-one-hot anodes are ignored
    hold(4'b0011, 7'b0110000, 1'b0, 20);
    hold(4'b0000, 7'b0110000, 1'b0, 20);
    chk("blank_digits", 32'(bus_h.digits), 32'h4321);
    chk("blank_valid", 32'(bus_h.digit_valid), 32'hB);

    // Active-low instance sees anode 1110 and segments 0000000, i.e. an '8' on digit 0
    hold(4'b0001, 7'b1111111, 1'b0, 10);
    chk("al_digit0", 32'(bus_l.digits[3:0]), 32'h8);
    chk("al_valid0", 32'(bus_l.digit_valid[0]), 32'h1);

    // Randomized traffic, with one reset landing mid-stream
    for (int k = 0; k < 400; k++) begin
      logic [3:0] an;
      logic [6:0] sg;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       an = 4'(1 << $urandom_range(0, 3));
      else if (sel == 7) an = 4'b0000;
      else               an = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 7) sg = pat[$urandom_range(0, 15)];
      else                          sg = 7'($urandom_range(0, 127));
      if (k == 200) begin
        drive(4'b0001, 7'b0110000, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("mid_rst_valid", 32'(bus_h.digit_valid), 32'h0);
        rst_n = 1'b1;
        tick();
      end
      hold(an, sg, ($urandom_range(0, 15) == 0), int'($urandom_range(1, 14)));
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
